// File: rtl/mem_port_arbiter_if.sv
// Port-B request/return bundle shared by the two requesters and the memory port.
// The arbiter takes the slave view; requesters plus memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 18
);
  logic          r0_req;
  logic          r0_wr;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_din;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_wr;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_din;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;

  modport master (
    output r0_req, r0_wr, r0_addr, r0_din,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_wr, r1_addr, r1_din,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  m_wr, m_addr, m_din,
    output m_dout
  );

  modport slave (
    input  r0_req, r0_wr, r0_addr, r0_din,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_wr, r1_addr, r1_din,
    output r1_gnt, r1_rvalid, r1_rdata,
    output m_wr, m_addr, m_din,
    input  m_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for memory port B with registered command and 2-cycle tagged read return.
// Define MEMARB_RR_EN for round-robin with a MAX_BURST limit; otherwise r0 has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned AW        = 14,
  parameter int unsigned DW        = 18,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               b_clk,
  input logic               CLR,
  mem_port_arbiter_if.slave bus
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end

  logic gnt0, gnt1, xfer, win;

`ifdef MEMARB_RR_EN
  localparam int unsigned    CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pick;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // A burst continues only once started, so cnt=0 after reset hands the first tie to r0.
    pick = ((cnt_q != '0) && (cnt_q < CntMax)) ? last_q : ~last_q;
    if (!CLR) begin
      case ({bus.r1_req, bus.r0_req})
        2'b01:   gnt0 = 1'b1;
        2'b10:   gnt1 = 1'b1;
        2'b11: begin
          gnt0 = ~pick;
          gnt1 = pick;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      last_d = win;
      if (win != last_q)       cnt_d = CntW'(1);
      else if (cnt_q < CntMax) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge b_clk) begin
    if (CLR) begin
      last_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  always_comb begin
    gnt0 = ~CLR & bus.r0_req;
    gnt1 = ~CLR & bus.r1_req & ~bus.r0_req;
  end
`endif

  assign xfer = gnt0 | gnt1;
  assign win  = gnt1;

  logic          m_wr_q, m_wr_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_din_q, m_din_d;
  logic          s1_rd_q, s1_rd_d, s1_id_q, s1_id_d;
  logic          s2_rd_q, s2_id_q;

  always_comb begin
    m_wr_d   = 1'b0;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    s1_rd_d  = 1'b0;
    s1_id_d  = win;
    if (xfer) begin
      m_wr_d   = win ? bus.r1_wr   : bus.r0_wr;
      m_addr_d = win ? bus.r1_addr : bus.r0_addr;
      m_din_d  = win ? bus.r1_din  : bus.r0_din;
      s1_rd_d  = ~m_wr_d;
    end
  end

  always_ff @(posedge b_clk) begin
    if (CLR) begin
      m_wr_q   <= 1'b0;
      m_addr_q <= '0;
      m_din_q  <= '0;
      s1_rd_q  <= 1'b0;
      s1_id_q  <= 1'b0;
      s2_rd_q  <= 1'b0;
      s2_id_q  <= 1'b0;
    end else begin
      m_wr_q   <= m_wr_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
      s1_rd_q  <= s1_rd_d;
      s1_id_q  <= s1_id_d;
      s2_rd_q  <= s1_rd_q;
      s2_id_q  <= s1_id_q;
    end
  end

  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = s2_rd_q & ~s2_id_q;
  assign bus.r1_rvalid = s2_rd_q & s2_id_q;
  assign bus.r0_rdata  = bus.m_dout;
  assign bus.r1_rdata  = bus.m_dout;
  assign bus.m_wr      = m_wr_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_din     = m_din_q;

endmodule
